// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: default geometry,
// operation-mode encoding and the stage-0 carry-in selection.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Subtraction is A + ~B + 1, so the external carry-in only matters when adding.
    function automatic logic stage0_cin(input logic sub, input logic c_in);
        return (mode_e'(sub) == MODE_SUB) ? 1'b1 : c_in;
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational CHUNK-bit ripple adder. c_msb_in exposes the carry into the top
// bit so the final chunk can report two's-complement overflow.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum[i]),
            .cout (carry_s[i+1])
        );
    end

    assign cout     = carry_s[CHUNK];
    assign c_msb_in = carry_s[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_full_adder.sv
// Single-bit full adder cell; the ripple chains in adder_chunk are built from it.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit whose carry chain is cut into STAGES registered
// chunks, with valid/ready handshakes on both sides and bubble-collapsing advance.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES (1..WIDTH)");
    end

    logic [STAGES:0]                en_s;
    logic [STAGES-1:0]              v_r;
    logic [STAGES-1:0]              carry_r;
    logic [STAGES-1:0][WIDTH-1:0]   sum_r;
    logic [STAGES-1:0][WIDTH-1:0]   a_r;
    logic [STAGES-1:0][WIDTH-1:0]   b_r;
    logic                           ovf_r;

    logic [STAGES-1:0][WIDTH-1:0]   src_a_s;
    logic [STAGES-1:0][WIDTH-1:0]   src_b_s;
    logic [STAGES-1:0][WIDTH-1:0]   src_sum_s;
    logic [STAGES-1:0][WIDTH-1:0]   nxt_sum_s;
    logic [STAGES-1:0]              src_cin_s;
    logic [STAGES-1:0]              src_v_s;
    logic [STAGES-1:0][CHUNK-1:0]   ch_sum_s;
    logic [STAGES-1:0]              ch_cout_s;
    logic [STAGES-1:0]              ch_cmsb_s;
    logic [WIDTH-1:0]               b_in_s;
    logic                           unused_s;

    assign b_in_s = i_sub ? ~i_b : i_b;

    // Advance chain: a stage may load when it is empty or its successor is moving.
    always_comb begin
        en_s[STAGES] = i_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en_s[k] = !v_r[k] || en_s[k+1];
        end
    end

    // Upstream source of each stage: input port for stage 0, previous stage registers otherwise.
    always_comb begin
        src_a_s[0]   = i_a;
        src_b_s[0]   = b_in_s;
        src_cin_s[0] = stage0_cin(i_sub, i_c_in);
        src_sum_s[0] = {WIDTH{1'b0}};
        src_v_s[0]   = i_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]   = a_r[k-1];
            src_b_s[k]   = b_r[k-1];
            src_cin_s[k] = carry_r[k-1];
            src_sum_s[k] = sum_r[k-1];
            src_v_s[k]   = v_r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a        (src_a_s[k][CHUNK*k +: CHUNK]),
            .b        (src_b_s[k][CHUNK*k +: CHUNK]),
            .cin      (src_cin_s[k]),
            .sum      (ch_sum_s[k]),
            .cout     (ch_cout_s[k]),
            .c_msb_in (ch_cmsb_s[k])
        );
    end

    // Merge each stage's freshly computed chunk into the partial sum it inherits.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum_s[k]                   = src_sum_s[k];
            nxt_sum_s[k][CHUNK*k +: CHUNK] = ch_sum_s[k];
        end
    end

    // Stage registers; reset empties the pipe and clears the visible result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_r     <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            sum_r   <= {(STAGES*WIDTH){1'b0}};
            a_r     <= {(STAGES*WIDTH){1'b0}};
            b_r     <= {(STAGES*WIDTH){1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en_s[k]) begin
                    v_r[k]     <= src_v_s[k];
                    sum_r[k]   <= nxt_sum_s[k];
                    carry_r[k] <= ch_cout_s[k];
                    a_r[k]     <= src_a_s[k];
                    b_r[k]     <= src_b_s[k];
                end
            end
            if (en_s[STAGES-1]) begin
                ovf_r <= ch_cout_s[STAGES-1] ^ ch_cmsb_s[STAGES-1];
            end
        end
    end

    // Operand copies in the last stage and intermediate MSB carries have no consumer.
    assign unused_s = ^{a_r[STAGES-1], b_r[STAGES-1], ch_cmsb_s};

    assign o_ready = en_s[0];
    assign o_valid = v_r[STAGES-1];
    assign o_sum   = sum_r[STAGES-1];
    assign o_cout  = carry_r[STAGES-1];
    assign o_ovf   = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=2): constant vector table,
// random streams against a reference model, and a scoreboard queue in order.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 2;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c_in;
        logic       sub;
        res_t       exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_c_in;
    logic         i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_ovf;

    res_t q[$];
    res_t cur_exp;
    res_t mon_exp;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    vec_t vecs[11];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c_in  (i_c_in),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic c_in, input logic sub);
        logic [7:0] bp;
        logic       c0;
        logic [8:0] full;
        logic [7:0] low;
        res_t       r;
        bp     = sub ? ~b : b;
        c0     = sub ? 1'b1 : c_in;
        full   = {1'b0, a} + {1'b0, bp} + {8'd0, c0};
        low    = {1'b0, a[6:0]} + {1'b0, bp[6:0]} + {7'd0, c0};
        r.sum  = full[7:0];
        r.cout = full[8];
        r.ovf  = low[7] ^ full[8];
        return r;
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer, flush on reset.
    always @(negedge clk) begin
        if (i_rst) begin
            q.delete();
        end else begin
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("result_queued", 32'd0, 32'd1);
                end else begin
                    mon_exp = q.pop_front();
                    pops++;
                    chk("result", 32'({o_sum, o_cout, o_ovf}), 32'(mon_exp));
                end
            end
            if (i_valid && o_ready) q.push_back(cur_exp);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input res_t e, output int stalls);
        bit done;
        i_a = a; i_b = b; i_c_in = c; i_sub = s; cur_exp = e; i_valid = 1'b1;
        stalls = 0;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (o_ready) done = 1'b1;
            else stalls++;
            cycle();
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && (q.size() != 0 || o_valid); t++) cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         st;
        int         tot;
        int         lat;
        int         p0;
        logic [7:0] ra[16];
        logic [7:0] rb[16];
        logic       rc[16];
        logic       rs[16];
        logic [7:0] held;

        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0}};
        vecs[1]  = '{8'hFF, 8'h00, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0}};
        vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};
        vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, '{8'hFE, 1'b0, 1'b0}};
        vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1}};
        vecs[5]  = '{8'h7F, 8'h80, 1'b0, 1'b1, '{8'hFF, 1'b0, 1'b1}};
        vecs[6]  = '{8'h03, 8'h03, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b0}};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, '{8'hFF, 1'b1, 1'b0}};
        vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1}};
        vecs[9]  = '{8'h10, 8'h01, 1'b1, 1'b1, '{8'h0F, 1'b1, 1'b0}};
        vecs[10] = '{8'h0F, 8'h00, 1'b1, 1'b0, '{8'h10, 1'b0, 1'b0}};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_a = 8'h00; i_b = 8'h00; i_c_in = 1'b0; i_sub = 1'b0; cur_exp = '0;
        repeat (2) cycle();
        i_rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_sum", 32'(o_sum), 32'd0);
        chk("reset_cout", 32'(o_cout), 32'd0);
        chk("reset_ovf", 32'(o_ovf), 32'd0);
        chk("reset_ready", 32'(o_ready), 32'd1);
        cycle();

        // Single add: exact latency of STAGES cycles.
        send(vecs[0].a, vecs[0].b, vecs[0].c_in, vecs[0].sub, vecs[0].exp, st);
        i_valid = 1'b0;
        lat = 1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (o_valid) break;
            cycle();
            lat++;
        end
        chk("latency", 32'(lat), 32'd2);
        drain();

        // Constant vector table, back to back.
        for (int i = 1; i < 11; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub, vecs[i].exp, st);
        end
        i_valid = 1'b0;
        drain();

        // Back-pressure: 5 operands while the output is stalled for 4 cycles.
        for (int i = 0; i < 5; i++) begin
            ra[i] = 8'($urandom); rb[i] = 8'($urandom);
            rc[i] = 1'($urandom); rs[i] = 1'($urandom);
        end
        p0 = pops;
        held = 8'h00;
        i_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(ra[i], rb[i], rc[i], rs[i], model(ra[i], rb[i], rc[i], rs[i]), st);
                i_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (c == 2) held = o_sum;
                    if (c >= 2) begin
                        chk("bp_ready_low", 32'(o_ready), 32'd0);
                        chk("bp_valid_held", 32'(o_valid), 32'd1);
                    end
                    if (c == 3) chk("bp_sum_stable", 32'(o_sum), 32'(held));
                    cycle();
                end
                i_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(pops - p0), 32'd5);

        // Full throughput: 16 random operands back to back.
        for (int i = 0; i < 16; i++) begin
            ra[i] = 8'($urandom); rb[i] = 8'($urandom);
            rc[i] = 1'($urandom); rs[i] = 1'($urandom);
        end
        tot = 0;
        lat = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(ra[i], rb[i], rc[i], rs[i], model(ra[i], rb[i], rc[i], rs[i]), st);
                    tot += st;
                end
                i_valid = 1'b0;
            end
            begin
                int run;
                run = 0;
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    if (o_valid && i_ready) run++;
                    else run = 0;
                    if (run > lat) lat = run;
                end
            end
        join
        chk("tput_stalls", 32'(tot), 32'd0);
        chk("tput_run", 32'(lat), 32'd16);
        drain();

        // Reset while two results are in flight.
        send(8'h11, 8'h22, 1'b0, 1'b0, model(8'h11, 8'h22, 1'b0, 1'b0), st);
        send(8'h33, 8'h44, 1'b0, 1'b1, model(8'h33, 8'h44, 1'b0, 1'b1), st);
        i_valid = 1'b0;
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(o_valid), 32'd0);
            cycle();
        end
        chk("rst_queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
